// File: rtl/fetch_stage_pkg.sv
// Shared types for the fetch stage: machine word, opcodes, fetch FSM states and PC step.
package fetch_stage_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [5:0] {
    RTYPE = 6'h00,
    J     = 6'h02,
    JAL   = 6'h03,
    BEQ   = 6'h04,
    BNE   = 6'h05,
    HALT  = 6'h3F
  } opcode_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam word_t PC_STEP = 32'd4;

  function automatic logic is_halt(input word_t w);
    return w[31:26] == HALT;
  endfunction

endpackage

// File: rtl/if_id_latch.sv
// IF/ID pipeline register: instruction, its PC+4 and a valid bit.
// Priority is reset, then flush (valid drops, payload kept), then write.
module if_id_latch
  import fetch_stage_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  we_i,
  input  logic  flush_i,
  input  word_t instr_i,
  input  word_t npc_i,
  output word_t instr_o,
  output word_t npc_o,
  output logic  valid_o
);

  word_t instr_q;
  word_t npc_q;
  logic  valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_q <= 32'h0000_0000;
      npc_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (we_i) begin
      instr_q <= instr_i;
      npc_q   <= npc_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign npc_o   = npc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch stage: PC, fetch FSM, stall hold buffer and IF/ID latch.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_npc,
  output logic        ifid_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cyc
`endif
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        hold_q, hold_d;
  word_t        pc_plus4_s;
  word_t        lat_instr_s;
  logic         lat_we_s;
  logic         lat_flush_s;
  logic         ren_q;

  assign pc_plus4_s = pc_q + PC_STEP;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_d      = hold_q;
    lat_we_s    = 1'b0;
    lat_flush_s = 1'b0;
    lat_instr_s = imemload;
    if (redirect) begin
      // Wrong-path work is dropped: any held or arriving word, and a HALT in flight.
      pc_d        = redirect_pc;
      hold_d      = 32'h0000_0000;
      state_d     = FETCH;
      lat_flush_s = 1'b1;
    end else begin
      case (state_q)
        FETCH: begin
          if (ihit && !stall) begin
            lat_we_s    = 1'b1;
            lat_instr_s = imemload;
          end else if (ihit && stall) begin
            hold_d  = imemload;
            state_d = HOLD;
          end else if (!ihit && !stall) begin
            lat_flush_s = 1'b1;
          end else begin
            state_d = state_q;
          end
        end
        HOLD: begin
          if (!stall) begin
            lat_we_s    = 1'b1;
            lat_instr_s = hold_q;
            state_d     = FETCH;
          end else begin
            state_d = state_q;
          end
        end
        HALTED: begin
          if (!stall) begin
            lat_flush_s = 1'b1;
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = FETCH;
        end
      endcase
      // A delivered HALT freezes the PC on its own address.
      if (lat_we_s) begin
        if (is_halt(lat_instr_s)) begin
          state_d = HALTED;
        end else begin
          pc_d = pc_plus4_s;
        end
      end else begin
        pc_d = pc_d;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      hold_q  <= 32'h0000_0000;
      ren_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      ren_q   <= (state_d == FETCH);
    end
  end

  assign imemREN  = ren_q;
  assign imemaddr = pc_q;

  if_id_latch u_if_id_latch (
    .clk_i   (CLK),
    .rst_i   (RST),
    .we_i    (lat_we_s),
    .flush_i (lat_flush_s),
    .instr_i (lat_instr_s),
    .npc_i   (pc_plus4_s),
    .instr_o (ifid_instr),
    .npc_o   (ifid_npc),
    .valid_o (ifid_valid)
  );

`ifdef FETCH_PERF_EN
  word_t fetch_cnt_q;
  word_t stall_cyc_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_cnt_q <= 32'h0000_0000;
      stall_cyc_q <= 32'h0000_0000;
    end else begin
      if (lat_we_s) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (stall && !redirect && (state_q != HALTED)) begin
        stall_cyc_q <= stall_cyc_q + 32'd1;
      end
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cyc = stall_cyc_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios followed by random traffic,
// each cycle's expected outputs come from a behavioural model and are queued for a monitor.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        ihit = 1'b0;
  logic [31:0] imemload = 32'h0;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_npc;
  logic        ifid_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cyc;
`endif

  fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
    .CLK         (clk),
    .RST         (RST),
    .ihit        (ihit),
    .imemload    (imemload),
    .imemREN     (imemREN),
    .imemaddr    (imemaddr),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ifid_instr  (ifid_instr),
    .ifid_npc    (ifid_npc),
    .ifid_valid  (ifid_valid)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .stall_cyc   (stall_cyc)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ren;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] npc;
    logic [31:0] fcnt;
    logic [31:0] scnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;

  // Behavioural model: mode 0 = fetching, 1 = holding a word, 2 = halted.
  int          m_mode = 0;
  logic [31:0] m_pc = 32'h0, m_held = 32'h0;
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = 32'h0, m_npc = 32'h0, m_fc = 32'h0, m_sc = 32'h0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {1'b0, a[6:2], a[27:2] ^ 26'h2A5_5A5A};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic deliver(input logic [31:0] w);
    m_instr = w;
    m_npc   = m_pc + 32'd4;
    m_valid = 1'b1;
    m_fc    = m_fc + 32'd1;
    if (w[31:26] == 6'h3F) m_mode = 2;
    else begin
      m_pc   = m_pc + 32'd4;
      m_mode = 0;
    end
  endtask

  task automatic model_step(input logic r, ih, st, rd, input logic [31:0] rp, input logic [31:0] load);
    if (r) begin
      m_pc = 32'h0; m_mode = 0; m_valid = 1'b0; m_instr = 32'h0; m_npc = 32'h0;
      m_fc = 32'h0; m_sc = 32'h0;
    end else begin
      if (st && !rd && m_mode != 2) m_sc = m_sc + 32'd1;
      if (rd) begin
        m_pc = rp; m_valid = 1'b0; m_mode = 0;
      end else if (m_mode == 0) begin
        if (ih && !st) deliver(load);
        else if (ih && st) begin m_held = load; m_mode = 1; end
        else if (!ih && !st) m_valid = 1'b0;
      end else if (m_mode == 1) begin
        if (!st) deliver(m_held);
      end else begin
        if (!st) m_valid = 1'b0;
      end
    end
  endtask

  task automatic cyc(input logic r, ih, st, rd, input logic [31:0] rp, input logic hlt);
    exp_t e;
    @(negedge clk);
    RST = r; ihit = ih; stall = st; redirect = rd; redirect_pc = rp;
    imemload = hlt ? 32'hFFFF_FFFF : (ih ? word_of(m_pc) : $urandom);
    model_step(r, ih, st, rd, rp, imemload);
    e.ren = (m_mode == 0); e.addr = m_pc; e.valid = m_valid;
    e.instr = m_instr; e.npc = m_npc; e.fcnt = m_fc; e.scnt = m_sc;
    exp_q.push_back(e);
    mon_en = 1'b1;
  endtask

  // Monitor: one expectation per clock, compared just after the edge.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL scoreboard_underflow at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("imemREN", {31'b0, imemREN}, {31'b0, e.ren});
        chk("imemaddr", imemaddr, e.addr);
        chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, e.valid});
        if (e.valid) begin
          chk("ifid_instr", ifid_instr, e.instr);
          chk("ifid_npc", ifid_npc, e.npc);
        end
`ifdef FETCH_PERF_EN
        chk("fetch_cnt", fetch_cnt, e.fcnt);
        chk("stall_cyc", stall_cyc, e.scnt);
`endif
      end
    end
  end

  initial begin
    // 1: reset then back-to-back hits
    cyc(1, 0, 0, 0, 32'h0, 0);
    cyc(1, 0, 0, 0, 32'h0, 0);
    repeat (3) cyc(0, 1, 0, 0, 32'h0, 0);
    // 2: three misses per fetch
    repeat (2) begin
      repeat (3) cyc(0, 0, 0, 0, 32'h0, 0);
      cyc(0, 1, 0, 0, 32'h0, 0);
    end
    // 3: hit under stall at PC=8, stall held two more cycles, then released
    cyc(1, 0, 0, 0, 32'h0, 0);
    repeat (2) cyc(0, 1, 0, 0, 32'h0, 0);
    cyc(0, 1, 1, 0, 32'h0, 0);
    repeat (2) cyc(0, 0, 1, 0, 32'h0, 0);
    cyc(0, 0, 0, 0, 32'h0, 0);
    repeat (2) cyc(0, 1, 0, 0, 32'h0, 0);
    // 4: redirect coincident with a hit at PC=0x10
    cyc(0, 0, 0, 1, 32'h10, 0);
    cyc(0, 1, 1, 1, 32'h40, 0);
    repeat (2) cyc(0, 1, 0, 0, 32'h0, 0);
    // 5: HALT fetched, held under stall, then wrong-path redirect to 0x80
    cyc(0, 1, 0, 0, 32'h0, 1);
    cyc(0, 1, 1, 0, 32'h0, 0);
    repeat (2) cyc(0, 1, 0, 0, 32'h0, 0);
    cyc(0, 0, 1, 1, 32'h80, 0);
    repeat (2) cyc(0, 1, 0, 0, 32'h0, 0);
    // PC wrap at the top of the address space
    cyc(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
    repeat (2) cyc(0, 1, 0, 0, 32'h0, 0);
    // 6: reset while holding a word
    cyc(0, 1, 1, 0, 32'h0, 0);
    cyc(0, 0, 1, 0, 32'h0, 0);
    cyc(1, 1, 1, 1, 32'h100, 0);
    repeat (2) cyc(0, 1, 0, 0, 32'h0, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, ih, st, rd, h;
      r  = ($urandom_range(0, 199) == 0);
      ih = ($urandom_range(0, 99) < 70);
      st = ($urandom_range(0, 99) < 25);
      rd = ($urandom_range(0, 99) < 5);
      h  = ($urandom_range(0, 99) < 3);
      cyc(r, ih, st, rd, ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : {22'h0, $urandom_range(0, 255), 2'b00}, h);
    end
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
